ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M/RV64M multiply/divide unit for the EX stage. It sits beside the single-cycle ALU.
- Decode steers an OP_OP instruction with func7=0000001 here, together with the same reg1/reg2/wd/wreg fields the ALU receives.
- The unit stalls the pipeline while it iterates. It returns a registered writeback triple for one cycle.
- It is the parametrised, sequential successor to the combinational execute path: width and radix are configurable, and it adds a handshake, flush and special-case handling.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- STEP, 1, bits retired per iteration cycle (1, 2 or 4; must divide XLEN).
- N (derived, localparam), XLEN/STEP, iteration cycle count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  valid M-extension op presented this cycle.
- func3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- reg1_i  in  XLEN  rs1 value (multiplicand/dividend).
- reg2_i  in  XLEN  rs2 value (multiplier/divisor).
- wd_i  in  5  destination register address.
- wreg_i  in  1  write-enable to pass through.
- flush_i  in  1  kill the in-flight op (branch/exception).
- busy_o  out  1  state != IDLE.
- stall_req_o  out  1  pipeline stall request (combinational).
- done_o  out  1  one-cycle result-valid pulse.
- wd_o  out  5  destination address of the result.
- wreg_o  out  1  write-enable of the result.
- wdata_o  out  XLEN  result.

Behaviour:
- Reset: state=IDLE. busy_o, done_o, wreg_o=0. wd_o=0, wdata_o=0. All internal registers cleared.
- States: IDLE, CALC, DONE.
- IDLE → CALC when start_i=1 and flush_i=0 and no special case applies. On that edge, latch func3, wd, wreg, operand magnitudes, result sign, and iteration counter=N-1.
- IDLE → DONE directly for division special cases:
  - divisor==0: quotient = all-ones; remainder = dividend.
  - signed overflow, dividend = -2^(XLEN-1) and divisor = -1: quotient = dividend; remainder = 0.
- CALC:
  - Multiply: shift-add STEP bits per cycle into a 2*XLEN accumulator.
  - Divide: restoring division, STEP quotient bits per cycle.
  - When counter==0, apply sign fixup (two's-complement negate if the sign flag is set) and go to DONE. Otherwise decrement the counter.
- DONE: done_o=1, with wdata_o/wd_o/wreg_o valid. Next state is IDLE, unconditionally.
- Outside DONE, done_o=0, wreg_o=0 and wdata_o holds its last value. Consumers qualify on done_o.
- Latency:
  - Normal op accepted at edge k: done_o is high in cycle k+N+1 (XLEN=32, STEP=1: 33 cycles after the start cycle).
  - Special case: done_o is high in cycle k+1.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits of the signed×signed / signed×unsigned / unsigned×unsigned product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). Only signed variants apply signs.
- stall_req_o = (state==CALC) | (state==IDLE & start_i & !flush_i). It is deasserted in DONE so the pipeline advances while capturing the result.
- start_i while state != IDLE: ignored. The decoder must hold the instruction under stall; it is not re-accepted after DONE unless presented again.
- flush_i in CALC or DONE: next state IDLE, done_o forced 0 that cycle, result discarded.
- flush_i together with start_i in IDLE: flush wins, nothing is accepted.
- rst has priority over everything, in any state.
- Invalid func3 cannot occur (3-bit field fully decoded).
- Arithmetic: operands are zero-/sign-extended to XLEN+1 for MULHSU. The accumulator is 2*XLEN+1 bits wide to hold the carry.

Decomposition:
- Shared defines:
  - FUNCT7_MULDIV (0000001).
  - The eight FUNCT3_MUL…FUNCT3_REMU codes.
  - State encodings EXMD_IDLE/CALC/DONE.
- One natural sub-module, muldiv_iter_step: the combinational STEP-bit shift-add / restoring-subtract slice instantiated inside CALC. The FSM, sign fixup and special-case logic stay in ex_muldiv.

Test Plan:
- MUL, reg1=7, reg2=0xFFFFFFFD (-3), start at cycle 0 → stall_req_o high cycles 0–32, done_o in cycle 33, wdata_o=0xFFFFFFEB, wd_o/wreg_o echo the inputs.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU of the same operands → 0x40000000. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases:
  - DIVU 0x1234/0 → 0xFFFFFFFF; REMU → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - done_o in cycle 1 for every special case.
- Flush and reset:
  - flush_i at cycle 10 of a DIV → no done_o, busy_o=0 at cycle 11; a new MUL started at cycle 11 completes correctly.
  - rst at cycle 5 → all outputs 0 the next cycle.
- Parameter sweep XLEN=64, STEP=4 over random operands against a reference model → done at cycle 17, results match; start_i pulsed during CALC is ignored.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the iterative M-extension unit.
// Decode and the EX stage both pull these in.
package ex_muldiv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    EXMD_IDLE = 2'd0,
    EXMD_CALC = 2'd1,
    EXMD_DONE = 2'd2
  } exmd_state_e;

endpackage

// File: rtl/ex_muldiv_iter_step.sv
// One CALC iteration: STEP bits of shift-add multiply or
// restoring divide on the shared {hi, lo} accumulator.
module muldiv_iter_step #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            is_div,
  input  logic [2*XLEN:0] acc_i,
  input  logic [XLEN-1:0] opb,
  output logic [2*XLEN:0] acc_o
);

  logic [2*XLEN:0] a;
  logic [XLEN:0]   hi;

  // Multiply: lo holds the multiplier, product grows into hi.
  // Divide: hi is the partial remainder, lo the dividend/quotient.
  always_comb begin
    a  = acc_i;
    hi = '0;
    for (int i = 0; i < STEP; i++) begin
      if (is_div) begin
        a  = a << 1;
        hi = a[2*XLEN:XLEN];
        if (hi >= {1'b0, opb}) begin
          a[2*XLEN:XLEN] = hi - {1'b0, opb};
          a[0]           = 1'b1;
        end
      end else begin
        hi = a[2*XLEN:XLEN];
        if (a[0]) hi = hi + {1'b0, opb};
        a = {hi, a[XLEN-1:0]} >> 1;
      end
    end
    acc_o = a;
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide beside the EX-stage ALU.
// Stalls the pipe while iterating; result valid for one cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [XLEN-1:0] reg1_i,
  input  logic [XLEN-1:0] reg2_i,
  input  logic [4:0]      wd_i,
  input  logic            wreg_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [4:0]      wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o
);

  localparam int N  = XLEN / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  exmd_state_e     state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic            wreg_q;
  logic            neg_q;
  logic [XLEN-1:0] opb_q;
  logic [2*XLEN:0] acc_q;
  logic [2*XLEN:0] acc_nxt;

  logic            sa, sb, neg_i;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div0, ovf, special;
  logic [XLEN-1:0] spec_res;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dres, res;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (func3_i)
      FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM: begin
        sa = reg1_i[XLEN-1];
        sb = reg2_i[XLEN-1];
      end
      FUNCT3_MULHSU: sa = reg1_i[XLEN-1];
      default: ;
    endcase
    neg_i = (func3_i == FUNCT3_REM) ? sa : (sa ^ sb);
    mag_a = sa ? -reg1_i : reg1_i;
    mag_b = sb ? -reg2_i : reg2_i;
  end

  // Division corner cases resolve in IDLE without iterating.
  always_comb begin
    div0 = func3_i[2] && (reg2_i == '0);
    ovf  = func3_i[2] && !func3_i[0]
        && (reg1_i == {1'b1, {(XLEN-1){1'b0}}})
        && (reg2_i == '1);
    special  = div0 || ovf;
    spec_res = '0;
    unique case (1'b1)
      div0:    spec_res = func3_i[1] ? reg1_i : '1;
      default: spec_res = func3_i[1] ? '0 : reg1_i;
    endcase
  end

  muldiv_iter_step #(
    .XLEN(XLEN),
    .STEP(STEP)
  ) u_step (
    .is_div(f3_q[2]),
    .acc_i (acc_q),
    .opb   (opb_q),
    .acc_o (acc_nxt)
  );

  always_comb begin
    prod = acc_nxt[2*XLEN-1:0];
    if (neg_q) prod = -prod;
    dres = f3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    if (neg_q) dres = -dres;
    res = '0;
    unique case (1'b1)
      f3_q[2]:              res = dres;
      f3_q == FUNCT3_MUL:   res = prod[XLEN-1:0];
      default:              res = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EXMD_IDLE;
      cnt     <= '0;
      f3_q    <= '0;
      wd_o    <= '0;
      wreg_q  <= 1'b0;
      neg_q   <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      wdata_o <= '0;
    end else begin
      unique case (state)
        EXMD_IDLE: begin
          if (start_i && !flush_i) begin
            f3_q   <= func3_i;
            wd_o   <= wd_i;
            wreg_q <= wreg_i;
            neg_q  <= neg_i;
            opb_q  <= mag_b;
            acc_q  <= {{(XLEN+1){1'b0}}, mag_a};
            cnt    <= CNT_LAST;
            if (special) begin
              wdata_o <= spec_res;
              state   <= EXMD_DONE;
            end else begin
              state   <= EXMD_CALC;
            end
          end
        end
        EXMD_CALC: begin
          if (flush_i) begin
            state <= EXMD_IDLE;
          end else begin
            acc_q <= acc_nxt;
            if (cnt == '0) begin
              wdata_o <= res;
              state   <= EXMD_DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        EXMD_DONE: state <= EXMD_IDLE;
        default:   state <= EXMD_IDLE;
      endcase
    end
  end

  assign busy_o      = (state != EXMD_IDLE);
  assign stall_req_o = (state == EXMD_CALC)
                    || ((state == EXMD_IDLE) && start_i && !flush_i);
  assign done_o      = (state == EXMD_DONE) && !flush_i;
  assign wreg_o      = done_o && wreg_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: 32-bit radix-2 instance plus a
// 64-bit radix-16 instance checked against a behavioural model.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        s32, fl32, we32;
  logic [2:0]  f32;
  logic [31:0] a32, b32;
  logic [4:0]  wd32;
  logic        busy32, st32, dn32, weo32;
  logic [4:0]  wdo32;
  logic [31:0] wdat32;

  logic        s64, fl64, we64;
  logic [2:0]  f64;
  logic [63:0] a64, b64;
  logic [4:0]  wd64;
  logic        busy64, st64, dn64, weo64;
  logic [4:0]  wdo64;
  logic [63:0] wdat64;

  ex_muldiv u32 (
    .clk(clk), .rst(rst), .start_i(s32), .func3_i(f32),
    .reg1_i(a32), .reg2_i(b32), .wd_i(wd32), .wreg_i(we32),
    .flush_i(fl32), .busy_o(busy32), .stall_req_o(st32),
    .done_o(dn32), .wd_o(wdo32), .wreg_o(weo32), .wdata_o(wdat32)
  );

  ex_muldiv #(.XLEN(64), .STEP(4)) u64 (
    .clk(clk), .rst(rst), .start_i(s64), .func3_i(f64),
    .reg1_i(a64), .reg2_i(b64), .wd_i(wd64), .wreg_i(we64),
    .flush_i(fl64), .busy_o(busy64), .stall_req_o(st64),
    .done_o(dn64), .wd_o(wdo64), .wreg_o(weo64), .wdata_o(wdat64)
  );

  function automatic logic [63:0] ref64(logic [2:0] f, logic [63:0] a,
                                        logic [63:0] b);
    logic [127:0] p;
    logic signed [63:0] sa, sb;
    logic ov;
    sa = a;
    sb = b;
    ov = (a == 64'h8000_0000_0000_0000) && (b == '1);
    case (f)
      FUNCT3_MUL:    p = {64'b0, a} * {64'b0, b};
      FUNCT3_MULH:   p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
      FUNCT3_MULHSU: p = {{64{a[63]}}, a} * {64'b0, b};
      FUNCT3_MULHU:  p = {64'b0, a} * {64'b0, b};
      default:       p = '0;
    endcase
    case (f)
      FUNCT3_MUL:  return p[63:0];
      FUNCT3_DIV:  return (b == 0) ? '1 : ov ? a : 64'(sa / sb);
      FUNCT3_DIVU: return (b == 0) ? '1 : a / b;
      FUNCT3_REM:  return (b == 0) ? a : ov ? '0 : 64'(sa % sb);
      FUNCT3_REMU: return (b == 0) ? a : a % b;
      default:     return p[127:64];
    endcase
  endfunction

  // Starts an op in the current cycle (cycle 0) and waits for done.
  task automatic op32(input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] w,
                      input logic we, output int lat,
                      output logic [31:0] d, output logic [4:0] wdo,
                      output logic weo, output logic st_ok);
    st_ok = 1'b1;
    lat = -1;
    d = 'x;
    wdo = 'x;
    weo = 1'bx;
    f32 = f; a32 = a; b32 = b; wd32 = w; we32 = we; s32 = 1'b1;
    #1;
    if (!st32) st_ok = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      s32 = 1'b0;
      if (dn32) begin
        lat = c; d = wdat32; wdo = wdo32; weo = weo32;
        if (st32) st_ok = 1'b0;
        break;
      end
      if (!st32) st_ok = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic op64(input logic [2:0] f, input logic [63:0] a,
                      input logic [63:0] b, input int poke,
                      output int lat, output logic [63:0] d);
    lat = -1;
    d = 'x;
    f64 = f; a64 = a; b64 = b; s64 = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      s64 = (c == poke);
      if (c == poke) begin
        f64 = FUNCT3_MULHU; a64 = '1; b64 = '1;
      end
      if (dn64) begin
        lat = c; d = wdat64;
        break;
      end
    end
    s64 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy32); end
    checks++; if (dn32 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", dn32); end
    checks++; if (weo32 !== 1'b0) begin failures++; $display("FAIL reset_wreg got=%b exp=0", weo32); end
    checks++; if (wdo32 !== 5'd0) begin failures++; $display("FAIL reset_wd got=%0d exp=0", wdo32); end
    checks++; if (wdat32 !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdat32); end
    checks++; if (busy64 !== 1'b0 || wdat64 !== 64'd0) begin failures++; $display("FAIL reset_64 busy=%b wdata=%h exp=0", busy64, wdat64); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int lat; logic [31:0] d; logic [4:0] w; logic we, ok;
    op32(FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd11, 1'b1, lat, d, w, we, ok);
    checks++; if (lat != 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (d !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_data got=%h exp=ffffffeb", d); end
    checks++; if (w !== 5'd11) begin failures++; $display("FAIL mul_wd got=%0d exp=11", w); end
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL mul_wreg got=%b exp=1", we); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mul_stall_window got=%b exp=1", ok); end
    op32(FUNCT3_MUL, 32'd6, 32'd9, 5'd4, 1'b0, lat, d, w, we, ok);
    checks++; if (d !== 32'd54 || we !== 1'b0) begin failures++; $display("FAIL mul_nowreg got=%h/%b exp=36/0", d, we); end
  endtask

  task automatic test_mulh;
    int lat; logic [31:0] d; logic [4:0] w; logic we, ok;
    op32(FUNCT3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'h4000_0000) begin failures++; $display("FAIL mulh got=%h exp=40000000", d); end
    op32(FUNCT3_MULHU, 32'h8000_0000, 32'h8000_0000, 5'd1, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'h4000_0000) begin failures++; $display("FAIL mulhu got=%h exp=40000000", d); end
    op32(FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu got=%h exp=ffffffff", d); end
    op32(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu_max got=%h exp=fffffffe", d); end
  endtask

  task automatic test_div;
    int lat; logic [31:0] d; logic [4:0] w; logic we, ok;
    op32(FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div got=%h exp=fffffffd", d); end
    checks++; if (lat != 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
    op32(FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem got=%h exp=ffffffff", d); end
    op32(FUNCT3_DIVU, 32'd100, 32'd7, 5'd2, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'd14) begin failures++; $display("FAIL divu got=%h exp=e", d); end
    op32(FUNCT3_REMU, 32'd100, 32'd7, 5'd2, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL remu got=%h exp=2", d); end
    op32(FUNCT3_REM, 32'd7, 32'hFFFF_FFFE, 5'd2, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL rem_negdiv got=%h exp=1", d); end
  endtask

  task automatic test_special;
    int lat; logic [31:0] d; logic [4:0] w; logic we, ok;
    op32(FUNCT3_DIVU, 32'h1234, 32'd0, 5'd7, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'hFFFF_FFFF || lat != 1) begin failures++; $display("FAIL divu_by0 got=%h lat=%0d exp=ffffffff lat=1", d, lat); end
    checks++; if (w !== 5'd7 || ok !== 1'b1) begin failures++; $display("FAIL divu_by0_wd got=%0d stall_ok=%b exp=7/1", w, ok); end
    op32(FUNCT3_REMU, 32'h1234, 32'd0, 5'd7, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'h1234 || lat != 1) begin failures++; $display("FAIL remu_by0 got=%h lat=%0d exp=1234 lat=1", d, lat); end
    op32(FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'h8000_0000 || lat != 1) begin failures++; $display("FAIL div_ovf got=%h lat=%0d exp=80000000 lat=1", d, lat); end
    op32(FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'd0 || lat != 1) begin failures++; $display("FAIL rem_ovf got=%h lat=%0d exp=0 lat=1", d, lat); end
    op32(FUNCT3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'd0 || lat != 33) begin failures++; $display("FAIL divu_noovf got=%h lat=%0d exp=0 lat=33", d, lat); end
  endtask

  task automatic test_flush;
    int lat; logic [31:0] d; logic [4:0] w; logic we, ok;
    f32 = FUNCT3_DIV; a32 = 32'd1000; b32 = 32'd3; s32 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      s32 = 1'b0;
    end
    fl32 = 1'b1; #1;
    checks++; if (dn32 !== 1'b0) begin failures++; $display("FAIL flush_c10_done got=%b exp=0", dn32); end
    @(posedge clk); #1;
    fl32 = 1'b0;
    checks++; if (busy32 !== 1'b0 || dn32 !== 1'b0) begin failures++; $display("FAIL flush_c11 busy=%b done=%b exp=0/0", busy32, dn32); end
    op32(FUNCT3_MUL, 32'd12, 32'd13, 5'd5, 1'b1, lat, d, w, we, ok);
    checks++; if (d !== 32'd156 || lat != 33) begin failures++; $display("FAIL flush_then_mul got=%h lat=%0d exp=9c lat=33", d, lat); end
    s32 = 1'b1; fl32 = 1'b1; #1;
    checks++; if (st32 !== 1'b0) begin failures++; $display("FAIL flush_start_stall got=%b exp=0", st32); end
    @(posedge clk); #1;
    s32 = 1'b0; fl32 = 1'b0;
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", busy32); end
    f32 = FUNCT3_DIVU; a32 = 32'h55; b32 = 32'd0; s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    checks++; if (dn32 !== 1'b1) begin failures++; $display("FAIL done_pre_flush got=%b exp=1", dn32); end
    fl32 = 1'b1; #1;
    checks++; if (dn32 !== 1'b0 || weo32 !== 1'b0) begin failures++; $display("FAIL flush_in_done done=%b wreg=%b exp=0/0", dn32, weo32); end
    @(posedge clk); #1;
    fl32 = 1'b0;
    checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL flush_done_busy got=%b exp=0", busy32); end
  endtask

  task automatic test_reset_mid;
    f32 = FUNCT3_MUL; a32 = 32'd3; b32 = 32'd5; wd32 = 5'd9; s32 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      s32 = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy32 !== 1'b0 || dn32 !== 1'b0 || weo32 !== 1'b0) begin failures++; $display("FAIL rst_mid_ctl busy=%b done=%b wreg=%b exp=0", busy32, dn32, weo32); end
    checks++; if (wdo32 !== 5'd0 || wdat32 !== 32'd0) begin failures++; $display("FAIL rst_mid_data wd=%0d wdata=%h exp=0", wdo32, wdat32); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_xlen64;
    int lat; logic [63:0] d, a, b, e;
    for (int f = 0; f < 8; f++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (f == 7) b = {32'd0, $urandom} | 64'd1;
      e = ref64(3'(f), a, b);
      op64(3'(f), a, b, (f == 4) ? 5 : 0, lat, d);
      checks++; if (d !== e || lat != 17) begin failures++; $display("FAIL x64_f%0d a=%h b=%h got=%h lat=%0d exp=%h lat=17", f, a, b, d, lat, e); end
      if (f == 4) begin
        checks++; if (busy64 !== 1'b0) begin failures++; $display("FAIL x64_poke_busy got=%b exp=0", busy64); end
      end
    end
    op64(FUNCT3_MUL, '1, 64'd5, 0, lat, d);
    checks++; if (d !== 64'hFFFF_FFFF_FFFF_FFFB) begin failures++; $display("FAIL x64_mul got=%h exp=fffffffffffffffb", d); end
    op64(FUNCT3_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, lat, d);
    checks++; if (d !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL x64_mulh got=%h exp=4000000000000000", d); end
    op64(FUNCT3_REM, 64'h1234_5678, 64'd0, 0, lat, d);
    checks++; if (d !== 64'h1234_5678 || lat != 1) begin failures++; $display("FAIL x64_rem0 got=%h lat=%0d exp=12345678 lat=1", d, lat); end
    op64(FUNCT3_DIV, 64'h8000_0000_0000_0000, '1, 0, lat, d);
    checks++; if (d !== 64'h8000_0000_0000_0000 || lat != 1) begin failures++; $display("FAIL x64_ovf got=%h lat=%0d exp=8000000000000000 lat=1", d, lat); end
  endtask

  initial begin
    rst = 1'b1;
    s32 = 1'b0; fl32 = 1'b0; we32 = 1'b1; f32 = '0;
    a32 = '0; b32 = '0; wd32 = '0;
    s64 = 1'b0; fl64 = 1'b0; we64 = 1'b1; f64 = '0;
    a64 = '0; b64 = '0; wd64 = 5'd9;
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_special;
    test_flush;
    test_reset_mid;
    test_xlen64;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
